// File: rtl/credit_fifo_pkg.sv
// Shared SL3 link constants: register latency of the delay_regs links and the
// receive-buffer credit slack derived from it.
package credit_fifo_pkg;

  localparam int SL3_LINK_LATENCY = 5;
  localparam int SL3_CREDIT_SLACK = 2 * SL3_LINK_LATENCY;

  // Ceiling log2 for elaboration-time sizing.
  function automatic int clog2(input int value);
    int result;
    int remain;
    result = 0;
    remain = value - 1;
    while (remain > 0) begin
      result = result + 1;
      remain = remain >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/credit_fifo.sv
// Receive-side elastic buffer behind a delay_regs link: drops din_ready SLACK
// entries early so in-flight words always fit, and serves a FWFT output.
module credit_fifo
  import credit_fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int SLACK = SL3_CREDIT_SLACK,
  localparam int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic [WIDTH-1:0]  din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [WIDTH-1:0]  dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [ADDR_W:0]   occupancy,
  output logic              overflow
);

  localparam logic [ADDR_W:0]   CNT_ZERO_C = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   CNT_ONE_C  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_FULL_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_THR_C  = (ADDR_W+1)'(DEPTH - SLACK);
  localparam logic [ADDR_W-1:0] PTR_ZERO_C = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] PTR_ONE_C  = ADDR_W'(1);

  logic [WIDTH-1:0]  mem_r [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   count_r;
  logic [ADDR_W:0]   count_next_s;
  logic              din_ready_r;
  logic              overflow_r;
  logic              rd_s;
  logic              wr_s;
  logic              drop_s;

  // Event decode and next count; a read at full frees the slot for a same-edge write.
  always_comb begin
    rd_s         = 1'b0;
    wr_s         = 1'b0;
    drop_s       = 1'b0;
    count_next_s = count_r;
    rd_s   = (count_r != CNT_ZERO_C) && dout_ready;
    wr_s   = din_valid && ((count_r != CNT_FULL_C) || rd_s);
    drop_s = din_valid && !wr_s;
    case ({wr_s, rd_s})
      2'b10:   count_next_s = count_r + CNT_ONE_C;
      2'b01:   count_next_s = count_r - CNT_ONE_C;
      default: count_next_s = count_r;
    endcase
  end

  // Pointers, count, credit and sticky overflow flag.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr_r    <= PTR_ZERO_C;
      rd_ptr_r    <= PTR_ZERO_C;
      count_r     <= CNT_ZERO_C;
      din_ready_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      if (wr_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      end
      if (rd_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      end
      count_r     <= count_next_s;
      din_ready_r <= (count_next_s < CNT_THR_C);
      overflow_r  <= overflow_r | drop_s;
    end
  end

  // Storage array; contents need no reset since dout is masked while empty.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  assign dout_valid = (count_r != CNT_ZERO_C);
  assign dout       = dout_valid ? mem_r[rd_ptr_r] : {WIDTH{1'b0}};
  assign din_ready  = din_ready_r;
  assign occupancy  = count_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_credit_fifo.sv
// Bench for credit_fifo: queue-based reference model, a modelled 5+5 cycle
// upstream link, directed corners and a SLACK=2 instance for forced overflow.
module tb_credit_fifo;

  logic        clk;
  logic        arst_n;
  logic [31:0] din;
  logic        din_valid;
  logic        din_ready;
  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic [4:0]  occupancy;
  logic        overflow;

  logic [31:0] o_din;
  logic        o_din_valid;
  logic        o_din_ready;
  logic [31:0] o_dout;
  logic        o_dout_valid;
  logic        o_dout_ready;
  logic [4:0]  o_occupancy;
  logic        o_overflow;

  int          n_vec;
  int          n_err;
  int          peak;
  logic [31:0] seq;
  logic [31:0] mq[$];
  bit          m_ovf;
  bit          pipe_v[$];
  logic [31:0] pipe_d[$];
  bit          rdy_h[$];

  credit_fifo dut (
    .clk(clk), .arst_n(arst_n), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .occupancy(occupancy), .overflow(overflow)
  );

  credit_fifo #(.SLACK(2)) dut_ovf (
    .clk(clk), .arst_n(arst_n), .din(o_din), .din_valid(o_din_valid),
    .din_ready(o_din_ready), .dout(o_dout), .dout_valid(o_dout_valid),
    .dout_ready(o_dout_ready), .occupancy(o_occupancy), .overflow(o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of the main DUT against the queue model.
  task automatic cycle(input logic v, input logic [31:0] d, input logic r);
    bit rd;
    bit wr;
    din_valid  = v;
    din        = d;
    dout_ready = r;
    #1;
    chk("dout_valid", 32'(dout_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) chk("dout", dout, mq[0]);
    @(posedge clk);
    rd = r && (mq.size() != 0);
    wr = v && ((mq.size() < 16) || rd);
    if (rd) void'(mq.pop_front());
    if (wr) mq.push_back(d);
    if (v && !wr) m_ovf = 1'b1;
    if (mq.size() > peak) peak = mq.size();
    #1;
    chk("occupancy", 32'(occupancy), 32'(mq.size()));
    chk("din_ready", 32'(din_ready), 32'(mq.size() < 6));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic link_reset();
    pipe_v.delete();
    pipe_d.delete();
    rdy_h.delete();
    repeat (5) begin
      pipe_v.push_back(1'b0);
      pipe_d.push_back(32'd0);
      rdy_h.push_back(1'b0);
    end
  endtask

  // Upstream producer: sees din_ready 5 cycles late, its words land 5 cycles later.
  task automatic link_cycle(input int issue_pct, input logic r);
    bit          seen;
    bit          v;
    logic [31:0] d;
    seen = rdy_h.pop_front();
    v    = pipe_v.pop_front();
    d    = pipe_d.pop_front();
    if (seen && ($urandom_range(0, 99) < issue_pct)) begin
      pipe_v.push_back(1'b1);
      pipe_d.push_back(seq);
      seq = seq + 32'd1;
    end else begin
      pipe_v.push_back(1'b0);
      pipe_d.push_back(32'd0);
    end
    rdy_h.push_back(din_ready);
    cycle(v, d, r);
  endtask

  initial begin
    n_vec = 0; n_err = 0; peak = 0; seq = 32'd0; m_ovf = 1'b0;
    arst_n = 1'b0; din = 32'd0; din_valid = 1'b0; dout_ready = 1'b0;
    o_din = 32'd0; o_din_valid = 1'b0; o_dout_ready = 1'b0;
    #3;
    chk("rst_din_ready", 32'(din_ready), 32'd0);
    chk("rst_dout_valid", 32'(dout_valid), 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_dout", dout, 32'd0);
    @(negedge clk);
    @(negedge clk);
    arst_n = 1'b1;

    // Fill through the delayed link with a producer that always wants to send.
    link_reset();
    for (int i = 0; i < 40; i++) link_cycle(100, 1'b0);
    chk("fill_peak", 32'(peak), 32'd16);
    chk("fill_overflow", 32'(overflow), 32'd0);

    // Drain in order.
    for (int i = 0; i < 20; i++) link_cycle(0, 1'b1);
    chk("drain_empty", 32'(occupancy), 32'd0);

    // Full with simultaneous read and write for 20 cycles.
    for (int i = 0; i < 16; i++) begin cycle(1'b1, seq, 1'b0); seq = seq + 32'd1; end
    chk("full_occ", 32'(occupancy), 32'd16);
    for (int i = 0; i < 20; i++) begin cycle(1'b1, seq, 1'b1); seq = seq + 32'd1; end
    chk("rw_full_occ", 32'(occupancy), 32'd16);
    chk("rw_full_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 16; i++) cycle(1'b0, 32'd0, 1'b1);

    // Empty corner: single word with reader always ready.
    cycle(1'b1, 32'hA5A5_0001, 1'b1);
    chk("empty_no_bypass_occ", 32'(occupancy), 32'd1);
    cycle(1'b0, 32'd0, 1'b1);
    chk("empty_after_read", 32'(dout_valid), 32'd0);
    cycle(1'b0, 32'd0, 1'b1);

    // Forced overflow on the SLACK=2 instance: producer ignores din_ready.
    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      o_din_valid = 1'b1;
      o_din = 32'(i);
      @(posedge clk);
      #1;
      chk("ovf_occ", 32'(o_occupancy), 32'((i + 1 > 16) ? 16 : i + 1));
      chk("ovf_flag", 32'(o_overflow), 32'(i == 16));
      chk("ovf_ready", 32'(o_din_ready), 32'((((i + 1 > 16) ? 16 : i + 1)) < 14));
    end
    o_din_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("ovf_sticky", 32'(o_overflow), 32'd1);
      chk("ovf_hold_occ", 32'(o_occupancy), 32'd16);
    end
    o_dout_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("ovf_drain_valid", 32'(o_dout_valid), 32'd1);
      chk("ovf_drain_data", o_dout, 32'(i));
      @(posedge clk);
      #1;
    end
    chk("ovf_drain_end", 32'(o_dout_valid), 32'd0);
    chk("ovf_still_set", 32'(o_overflow), 32'd1);
    o_dout_ready = 1'b0;

    // Randomized legal traffic through the delayed link.
    link_reset();
    for (int blk = 0; blk < 8; blk++) begin
      int pct;
      int rpct;
      pct  = $urandom_range(20, 100);
      rpct = $urandom_range(10, 90);
      for (int i = 0; i < 100; i++) link_cycle(pct, 1'($urandom_range(0, 99) < rpct));
    end
    chk("rand_no_overflow", 32'(overflow), 32'd0);

    // Mid-operation reset at count 9.
    for (int i = 0; i < 60 && mq.size() != 0; i++) link_cycle(0, 1'b1);
    chk("pre_reset_empty", 32'(occupancy), 32'd0);
    for (int i = 0; i < 9; i++) begin cycle(1'b1, seq, 1'b0); seq = seq + 32'd1; end
    chk("pre_reset_occ", 32'(occupancy), 32'd9);
    #2;
    arst_n = 1'b0;
    #1;
    chk("mid_rst_dout_valid", 32'(dout_valid), 32'd0);
    chk("mid_rst_din_ready", 32'(din_ready), 32'd0);
    chk("mid_rst_occ", 32'(occupancy), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    mq.delete();
    m_ovf = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin cycle(1'b1, seq, 1'(i > 3)); seq = seq + 32'd1; end
    for (int i = 0; i < 12; i++) cycle(1'b0, 32'd0, 1'b1);
    chk("post_reset_empty", 32'(occupancy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/credit_fifo.md
Name: credit_fifo

Overview:
- Receive-side elastic buffer that sits directly downstream of a delay_regs pipeline.
- Accepts words that arrive a fixed number of cycles after the producer sampled din_ready. The producer's view of din_ready is also delayed.
- Absorbs that in-flight data by deasserting din_ready early by SLACK entries, and presents a first-word-fall-through valid/ready output to the consumer.
- Flags any overflow caused by a mismatched SLACK.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 16, number of storage entries. Must be a power of 2 and at least SLACK+2.
- SLACK, 10, worst-case words in flight after din_ready falls. Equals the round-trip register latency, ready path plus data path (2 x delay_regs LATENCY).
- ADDR_W, derived as log2(DEPTH), pointer width. Not user-set.

Ports:
- clk  input  1  single clock for all logic.
- arst_n  input  1  asynchronous active-low reset.
- din  input  WIDTH  write data, already delayed upstream.
- din_valid  input  1  din carries a word this cycle. Not gated by din_ready.
- din_ready  output  1  credit to the upstream producer, registered.
- dout  output  WIDTH  head-of-queue word (FWFT).
- dout_valid  output  1  dout is valid.
- dout_ready  input  1  consumer accepts dout this cycle.
- occupancy  output  ADDR_W+1  current entry count, registered.
- overflow  output  1  sticky: a write arrived while full.

Behaviour:
- Reset, asynchronous on arst_n low:
  - wr_ptr = rd_ptr = 0 and count = 0.
  - din_ready = 0, dout_valid = 0, occupancy = 0, overflow = 0.
  - dout = 0.
  - Storage contents are don't-care.
- First cycle after reset release: din_ready rises (count 0 < DEPTH-SLACK).
- Write event: din_valid=1 and count<DEPTH, where count is the value before this edge.
  - Storage at wr_ptr gets din.
  - wr_ptr increments modulo DEPTH; wrap from DEPTH-1 to 0 is natural.
- Write while count==DEPTH:
  - The word is dropped; pointers and count are unchanged.
  - overflow is set next cycle and stays set until reset.
- Read event: dout_valid=1 and dout_ready=1. rd_ptr increments modulo DEPTH.
- Count update rules:
  - Write only: +1.
  - Read only: -1.
  - Both: unchanged. This includes count==DEPTH with a simultaneous read: the write is accepted, because the read frees the slot at the same edge, and overflow is NOT set.
  - count==0 with din_valid and no read: +1.
- dout_valid = (count != 0), combinational from registered count.
- dout = storage at rd_ptr.
- A word written at edge N is visible on dout after edge N; write-to-dout latency is 1 cycle.
- No bypass: with count==0, din does not appear on dout in the same cycle.
- dout_ready while dout_valid=0 is ignored.
- din_ready is registered: din_ready <= (count_next < DEPTH-SLACK).
  - Deasserts on the edge that makes count reach DEPTH-SLACK.
  - Reasserts on the edge that drops count below it.
- occupancy <= count_next, i.e. equals count every cycle.
- With correct SLACK, overflow never sets under any legal upstream behaviour.
- Storage: register array, inferred as MLAB/registers. No read-during-write hazard, because reads use rd_ptr != wr_ptr whenever count != 0, or count==DEPTH with the simultaneous-read case.
- Mid-operation reset: all state clears immediately. In-flight upstream words arriving after release are accepted normally; no synchronisation of din_valid is required.
- Implementation: target 150-250 lines.

Decomposition:
- Shared SL3 package holds:
  - SL3_LINK_LATENCY, the delay_regs LATENCY used on the ready and data paths.
  - SL3_CREDIT_SLACK = 2*SL3_LINK_LATENCY, the instance default for SLACK.
  - A clog2 constant function.
- The module is a single flat module with no sub-module. Pointer/count logic and storage are small enough to stay inline.

Test Plan:
- Reset and fill: release reset, then drive din_valid=1 continuously with din=0..N, and feed din_ready back through a 5-cycle delay. Required: din_ready falls on the edge where occupancy reaches 6, all writes are accepted, overflow stays 0, and occupancy peaks at 16.
- Drain order: after the fill, hold dout_ready=1. Required: dout sequence 0,1,2,... with no gaps, dout_valid falls after the 16th word, and occupancy returns to 0.
- Simultaneous read/write at full: count=16, drive din_valid=1 and dout_ready=1 for 20 cycles. Required: count stays 16, overflow=0, order is preserved, and pointers wrap at least once.
- Forced overflow: SLACK instance 2, upstream ignores din_ready and writes 17 words with no reads. Required: 17th word dropped, overflow=1 from the next cycle, sticky, with occupancy=16.
- Empty corner: count=0, pulse din_valid one cycle with dout_ready=1 held. Required: dout_valid rises exactly one cycle after the write and drops after one cycle.
- Mid-operation reset: assert arst_n low asynchronously between edges at count=9. Required: dout_valid, din_ready and occupancy are 0 immediately, overflow=0, and normal operation resumes after release.
